hls_stream_to_xillybus_rd: RTL and testbench

Output-side adapter between an HLS core's `ap_fifo` output stream (`*_din` / `*_write` / `*_full_n`) and a Xillybus FPGA-to-host read stream (`user_r_*_rden` / `empty` / `data` / `eof` / `open`). It replaces the external read-side FIFO and ad-hoc glue with a self-contained circular buffer, flow control, delivered-word counting and optional end-of-file generation. It sits in `xillydemo` between the HLS core's output and `xillybus_ins`, mirroring the input-side empty_n adapter.

---
 rtl/hls_stream_to_xillybus_rd.sv | 147 ++++++++++++++
 tb/tb_hls_stream_to_xillybus_rd.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_stream_to_xillybus_rd.sv
// hls_stream_to_xillybus_rd
//
// Bridges an HLS ap_fifo output stream to a Xillybus FPGA-to-host read stream.
// It uses an internal circular buffer of 2^DEPTH_LOG2 words. It also counts the
// words delivered to the host and keeps a sticky overflow flag.
//
// Optional feature macro: HLS_RD_EOF_EN. When it is defined, the adapter
// closes the stream after FRAME_WORDS accepted words. It then raises
// user_r_eof once the buffer has drained.
//
// Ports:
//   ap_clk, ap_rst   clock and asynchronous active-high reset
//   out_arr_din      word from the HLS core
//   out_arr_write    HLS write strobe
//   out_arr_full_n   adapter can accept a word this cycle
//   user_r_rden      Xillybus pop request
//   user_r_empty     buffer empty
//   user_r_data      popped word, registered (valid the cycle after rden)
//   user_r_eof       end of file (tied low without HLS_RD_EOF_EN)
//   user_r_open      host has the device file open; low flushes all state
//   words_sent       words popped since open, wraps at 16 bits
//   overflow         sticky: a write arrived while out_arr_full_n was low
module hls_stream_to_xillybus_rd #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned FRAME_WORDS = 64
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DATA_W-1:0] out_arr_din,
  input  logic              out_arr_write,
  output logic              out_arr_full_n,
  input  logic              user_r_rden,
  output logic              user_r_empty,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_eof,
  input  logic              user_r_open,
  output logic [15:0]       words_sent,
  output logic              overflow
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

  if (FRAME_WORDS < 1 || FRAME_WORDS > 65535) begin : gen_bad_frame_words
    $error("FRAME_WORDS must be in 1..65535");
  end

  logic [DATA_W-1:0] mem [Depth];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   count;
  logic [15:0]       words_sent_q, words_sent_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] data_q;
  logic              acc, pop, frame_stop;

  // The extra pointer bit tells full (count == Depth) apart from empty.
  assign count          = wr_ptr_q - rd_ptr_q;
  assign user_r_empty   = (count == '0);
  // While closed, full_n is held high so the core never stalls.
  assign out_arr_full_n = ~user_r_open | ((count != PtrW'(Depth)) & ~frame_stop);
  // Writes to a closed device are silently dropped.
  assign acc            = out_arr_write & out_arr_full_n & user_r_open;
  assign pop            = user_r_rden & ~user_r_empty & user_r_open;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + PtrW'(acc);
    rd_ptr_d     = rd_ptr_q + PtrW'(pop);
    words_sent_d = words_sent_q + 16'(pop);
    overflow_d   = overflow_q | (out_arr_write & ~out_arr_full_n);
    if (!user_r_open) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      words_sent_d = '0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      words_sent_q <= '0;
      overflow_q   <= 1'b0;
      data_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      words_sent_q <= words_sent_d;
      overflow_q   <= overflow_d;
      if (pop) begin
        data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
      end
    end
  end

  // Storage has no reset; words behind the read pointer are never observed.
  always_ff @(posedge ap_clk) begin
    if (acc) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= out_arr_din;
    end
  end

  assign user_r_data = data_q;
  assign words_sent  = words_sent_q;
  assign overflow    = overflow_q;

`ifdef HLS_RD_EOF_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_stop_q, frame_stop_d;
  logic        eof_q, eof_d;

  always_comb begin
    frame_cnt_d  = frame_cnt_q + 16'(acc);
    frame_stop_d = frame_stop_q | (frame_cnt_d == 16'(FRAME_WORDS));
    // Raise eof on the same edge as the pop that drains the buffer, so that
    // eof and empty appear together.
    eof_d        = eof_q | (frame_stop_d & (wr_ptr_d == rd_ptr_d));
    if (!user_r_open) begin
      frame_cnt_d  = '0;
      frame_stop_d = 1'b0;
      eof_d        = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      frame_cnt_q  <= '0;
      frame_stop_q <= 1'b0;
      eof_q        <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      frame_stop_q <= frame_stop_d;
      eof_q        <= eof_d;
    end
  end

  assign frame_stop = frame_stop_q;
  assign user_r_eof = eof_q;
`else
  assign frame_stop = 1'b0;
  assign user_r_eof = 1'b0;
`endif

endmodule

// File: tb/tb_hls_stream_to_xillybus_rd.sv
module tb_hls_stream_to_xillybus_rd;

`ifdef HLS_RD_EOF_EN
  localparam int unsigned FrameWords = 4;
`else
  localparam int unsigned FrameWords = 64;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [31:0] out_arr_din;
  logic        out_arr_write;
  logic        out_arr_full_n;
  logic        user_r_rden;
  logic        user_r_empty;
  logic [31:0] user_r_data;
  logic        user_r_eof;
  logic        user_r_open;
  logic [15:0] words_sent;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  hls_stream_to_xillybus_rd #(
    .DATA_W     (32),
    .DEPTH_LOG2 (4),
    .FRAME_WORDS(FrameWords)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .out_arr_din   (out_arr_din),
    .out_arr_write (out_arr_write),
    .out_arr_full_n(out_arr_full_n),
    .user_r_rden   (user_r_rden),
    .user_r_empty  (user_r_empty),
    .user_r_data   (user_r_data),
    .user_r_eof    (user_r_eof),
    .user_r_open   (user_r_open),
    .words_sent    (words_sent),
    .overflow      (overflow)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; out_arr_din = '0; out_arr_write = 1'b0;
    user_r_rden = 1'b0; user_r_open = 1'b0;
    #3;
    checks++; if (out_arr_full_n !== 1'b1) begin errors++;
      $display("FAIL reset_full_n: got %b expected 1", out_arr_full_n); end
    checks++; if (user_r_empty !== 1'b1) begin errors++;
      $display("FAIL reset_empty: got %b expected 1", user_r_empty); end
    checks++; if (user_r_data !== 32'h0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", user_r_data); end
    checks++; if (user_r_eof !== 1'b0) begin errors++;
      $display("FAIL reset_eof: got %b expected 0", user_r_eof); end
    checks++; if (words_sent !== 16'd0) begin errors++;
      $display("FAIL reset_words_sent: got %0d expected 0", words_sent); end
    checks++; if (overflow !== 1'b0) begin errors++;
      $display("FAIL reset_overflow: got %b expected 0", overflow); end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    user_r_open = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
    out_arr_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_arr_din = exp_w[i];
      tick();
      if (i == 0) begin
        checks++; if (user_r_empty !== 1'b0) begin errors++;
          $display("FAIL basic_visible: got empty=%b expected 0", user_r_empty); end
      end
    end
    out_arr_write = 1'b0;
    user_r_rden = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (user_r_data !== exp_w[i]) begin errors++;
        $display("FAIL basic_data%0d: got %h expected %h", i, user_r_data, exp_w[i]); end
    end
    user_r_rden = 1'b0;
    checks++; if (user_r_empty !== 1'b1) begin errors++;
      $display("FAIL basic_empty: got %b expected 1", user_r_empty); end
    checks++; if (words_sent !== 16'd3) begin errors++;
      $display("FAIL basic_words_sent: got %0d expected 3", words_sent); end
  endtask

  task automatic test_empty_read();
    out_arr_din = 32'h55; out_arr_write = 1'b1;
    tick();
    out_arr_write = 1'b0; user_r_rden = 1'b1;
    tick();
    checks++; if (user_r_data !== 32'h55) begin errors++;
      $display("FAIL empty_pop: got %h expected 55", user_r_data); end
    tick();
    tick();
    user_r_rden = 1'b0;
    checks++; if (user_r_data !== 32'h55) begin errors++;
      $display("FAIL empty_hold: got %h expected 55", user_r_data); end
    checks++; if (words_sent !== 16'd4) begin errors++;
      $display("FAIL empty_words_sent: got %0d expected 4", words_sent); end
  endtask

  task automatic test_close();
    out_arr_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      out_arr_din = 32'h60 + i;
      tick();
    end
    out_arr_din = 32'hBAD;
    user_r_open = 1'b0;
    tick();
    checks++; if (user_r_empty !== 1'b1) begin errors++;
      $display("FAIL close_empty: got %b expected 1", user_r_empty); end
    checks++; if (words_sent !== 16'd0) begin errors++;
      $display("FAIL close_words_sent: got %0d expected 0", words_sent); end
    checks++; if (overflow !== 1'b0) begin errors++;
      $display("FAIL close_overflow: got %b expected 0", overflow); end
    checks++; if (out_arr_full_n !== 1'b1) begin errors++;
      $display("FAIL close_full_n: got %b expected 1", out_arr_full_n); end
    out_arr_write = 1'b0;
    user_r_open = 1'b1;
    tick();
    checks++; if (user_r_empty !== 1'b1) begin errors++;
      $display("FAIL reopen_empty: got %b expected 1", user_r_empty); end
    out_arr_din = 32'h77; out_arr_write = 1'b1;
    tick();
    out_arr_write = 1'b0; user_r_rden = 1'b1;
    tick();
    user_r_rden = 1'b0;
    checks++; if (user_r_data !== 32'h77) begin errors++;
      $display("FAIL reopen_data: got %h expected 77", user_r_data); end
    checks++; if (user_r_empty !== 1'b1) begin errors++;
      $display("FAIL reopen_drained: got %b expected 1", user_r_empty); end
  endtask

  task automatic test_full();
    out_arr_write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      out_arr_din = 32'h100 + i;
      tick();
      if (i == 14) begin
        checks++; if (out_arr_full_n !== 1'b1) begin errors++;
          $display("FAIL full_at15: got %b expected 1", out_arr_full_n); end
      end
    end
    checks++; if (out_arr_full_n !== 1'b0) begin errors++;
      $display("FAIL full_at16: got %b expected 0", out_arr_full_n); end
    checks++; if (overflow !== 1'b0) begin errors++;
      $display("FAIL full_no_overflow: got %b expected 0", overflow); end
    out_arr_din = 32'hDEAD;
    tick();
    out_arr_write = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++;
      $display("FAIL full_overflow: got %b expected 1", overflow); end
    checks++; if (out_arr_full_n !== 1'b0) begin errors++;
      $display("FAIL full_still_full: got %b expected 0", out_arr_full_n); end
    user_r_rden = 1'b1;
    tick();
    user_r_rden = 1'b0;
    checks++; if (user_r_data !== 32'h100) begin errors++;
      $display("FAIL full_pop_data: got %h expected 100", user_r_data); end
    checks++; if (out_arr_full_n !== 1'b1) begin errors++;
      $display("FAIL full_recover: got %b expected 1", out_arr_full_n); end
  endtask

  task automatic test_concurrent();
    logic [31:0] q [$];
    logic [31:0] exp_d;
    int n;
    // Buffer holds 0x101..0x10F; one more word fills it.
    for (int i = 1; i < 16; i++) q.push_back(32'h100 + i);
    out_arr_din = 32'h110; out_arr_write = 1'b1;
    tick();
    q.push_back(32'h110);
    checks++; if (out_arr_full_n !== 1'b0) begin errors++;
      $display("FAIL conc_full: got %b expected 0", out_arr_full_n); end
    // The core writes only when full_n is high, as ap_fifo does: at count 16
    // the first cycle is pop-only, then write and pop every cycle.
    user_r_rden = 1'b1;
    for (int k = 0; k < 100; k++) begin
      out_arr_write = (k != 0);
      out_arr_din   = 32'h200 + k;
      #1;
      checks++; if (out_arr_full_n !== (k != 0)) begin errors++;
        $display("FAIL conc_full_n%0d: got %b expected %b", k, out_arr_full_n, k != 0); end
      if (k != 0) q.push_back(32'h200 + k);
      @(posedge ap_clk);
      #1;
      exp_d = q.pop_front();
      checks++; if (user_r_data !== exp_d) begin errors++;
        $display("FAIL conc_data%0d: got %h expected %h", k, user_r_data, exp_d); end
    end
    user_r_rden = 1'b0; out_arr_write = 1'b0;
    checks++; if (words_sent !== 16'd102) begin errors++;
      $display("FAIL conc_words_sent: got %0d expected 102", words_sent); end
    checks++; if (overflow !== 1'b1) begin errors++;
      $display("FAIL conc_overflow_sticky: got %b expected 1", overflow); end
    n = 0;
    user_r_rden = 1'b1;
    while (user_r_empty === 1'b0 && n < 40) begin
      tick();
      exp_d = (q.size() != 0) ? q.pop_front() : 32'hFFFF_FFFF;
      checks++; if (user_r_data !== exp_d) begin errors++;
        $display("FAIL drain_data%0d: got %h expected %h", n, user_r_data, exp_d); end
      n++;
    end
    user_r_rden = 1'b0;
    checks++; if (n != 15) begin errors++;
      $display("FAIL drain_count: got %0d expected 15", n); end
    checks++; if (words_sent !== 16'd117) begin errors++;
      $display("FAIL drain_words_sent: got %0d expected 117", words_sent); end
  endtask

  task automatic test_reset_mid();
    out_arr_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_arr_din = 32'hA1 + i;
      tick();
    end
    out_arr_write = 1'b0;
    #3;
    ap_rst = 1'b1;
    #1;
    checks++; if (user_r_empty !== 1'b1) begin errors++;
      $display("FAIL midrst_empty: got %b expected 1", user_r_empty); end
    checks++; if (words_sent !== 16'd0) begin errors++;
      $display("FAIL midrst_words_sent: got %0d expected 0", words_sent); end
    checks++; if (user_r_data !== 32'h0) begin errors++;
      $display("FAIL midrst_data: got %h expected 0", user_r_data); end
    checks++; if (overflow !== 1'b0) begin errors++;
      $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    tick();
  endtask

  task automatic test_eof();
`ifdef HLS_RD_EOF_EN
    out_arr_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      out_arr_din = 32'h1 + i;
      tick();
      if (i == 3) begin
        checks++; if (out_arr_full_n !== 1'b0) begin errors++;
          $display("FAIL eof_stop: got %b expected 0", out_arr_full_n); end
      end
    end
    out_arr_write = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++;
      $display("FAIL eof_overflow: got %b expected 1", overflow); end
    user_r_rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (user_r_data !== 32'h1 + i) begin errors++;
        $display("FAIL eof_data%0d: got %h expected %h", i, user_r_data, 32'h1 + i); end
      if (i == 2) begin
        checks++; if (user_r_eof !== 1'b0) begin errors++;
          $display("FAIL eof_early: got %b expected 0", user_r_eof); end
      end
    end
    user_r_rden = 1'b0;
    checks++; if (user_r_eof !== 1'b1) begin errors++;
      $display("FAIL eof_set: got %b expected 1", user_r_eof); end
    checks++; if (user_r_empty !== 1'b1) begin errors++;
      $display("FAIL eof_empty: got %b expected 1", user_r_empty); end
    tick();
    checks++; if (user_r_eof !== 1'b1) begin errors++;
      $display("FAIL eof_hold: got %b expected 1", user_r_eof); end
    user_r_open = 1'b0;
    tick();
    checks++; if (user_r_eof !== 1'b0) begin errors++;
      $display("FAIL eof_clear: got %b expected 0", user_r_eof); end
    user_r_open = 1'b1;
    tick();
    checks++; if (out_arr_full_n !== 1'b1) begin errors++;
      $display("FAIL eof_restart: got %b expected 1", out_arr_full_n); end
`else
    out_arr_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      out_arr_din = 32'h1 + i;
      tick();
    end
    out_arr_write = 1'b0;
    user_r_rden = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    user_r_rden = 1'b0;
    checks++; if (user_r_eof !== 1'b0) begin errors++;
      $display("FAIL noeof_tied: got %b expected 0", user_r_eof); end
    checks++; if (user_r_data !== 32'h6) begin errors++;
      $display("FAIL noeof_data: got %h expected 6", user_r_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_read();
    test_close();
    test_full();
    test_concurrent();
    test_reset_mid();
    test_eof();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
